// File: rtl/id_pkg.sv
// Shared definitions for the instruction-decode stage: MIPS-I opcode and
// funct encodings, ALU operation encoding and the ID/EX pipeline record.
package id_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NREGS  = 32;
    localparam int unsigned REG_AW = $clog2(NREGS);

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    // R-type funct codes (instr[5:0])
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b100
    } alu_op_e;

    // ID/EX pipeline register contents; all-zero is a bubble.
    typedef struct packed {
        logic [XLEN-1:0]   pc4;
        logic [XLEN-1:0]   rs_data;
        logic [XLEN-1:0]   rt_data;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   jump_target;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rd;
        alu_op_e           alu_op;
        logic              alu_src;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              branch;
        logic              jump;
    } idex_t;

endpackage

// File: rtl/id_stage_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write
// port. r0 reads as zero and ignores writes. A write to the register being
// read in the same cycle is bypassed to the read data (write-first).
//   clk, reset         : clock, async active-high reset (clears all entries)
//   we_i/waddr_i/wdata_i : write port
//   raddr_a_i/rdata_a_o  : read port A
//   raddr_b_i/rdata_b_o  : read port B
module regfile
    import id_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic [REG_AW-1:0] raddr_a_i,
    output logic [XLEN-1:0]   rdata_a_o,
    input  logic [REG_AW-1:0] raddr_b_i,
    output logic [XLEN-1:0]   rdata_b_o
);

    logic [XLEN-1:0] mem_q [NREGS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && waddr_i != '0) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_a_o = '0;
        if (raddr_a_i != '0) begin
            rdata_a_o = (we_i && waddr_i == raddr_a_i) ? wdata_i : mem_q[raddr_a_i];
        end
    end

    always_comb begin
        rdata_b_o = '0;
        if (raddr_b_i != '0) begin
            rdata_b_o = (we_i && waddr_i == raddr_b_i) ? wdata_i : mem_q[raddr_b_i];
        end
    end

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage. Decodes a MIPS-I integer subset from the fetch
// register, reads the register file (with writeback bypass), detects
// load-use hazards and registers everything into the ID/EX register.
//   clk, reset          : clock, async active-high reset
//   if_instruction/if_next_pc : fetch stage outputs
//   flush               : squash the instruction in decode
//   wb_we/wb_rd/wb_data : writeback port into the register file
//   stall               : combinational; hold PC and fetch register
//   ex_*                : ID/EX pipeline register outputs
module id_stage
    import id_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [XLEN-1:0]   if_instruction,
    input  logic [XLEN-1:0]   if_next_pc,
    input  logic              flush,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic              stall,
    output logic [XLEN-1:0]   ex_pc4,
    output logic [XLEN-1:0]   ex_rs_data,
    output logic [XLEN-1:0]   ex_rt_data,
    output logic [XLEN-1:0]   ex_imm,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_rd,
    output logic [2:0]        ex_alu_op,
    output logic              ex_alu_src,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_branch,
    output logic              ex_jump,
    output logic [XLEN-1:0]   ex_jump_target
);

    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [REG_AW-1:0] rs_f;
    logic [REG_AW-1:0] rt_f;
    logic [REG_AW-1:0] rd_f;
    logic [XLEN-1:0]   rs_rdata;
    logic [XLEN-1:0]   rt_rdata;

    idex_t dec;
    logic  legal;
    logic  uses_rt;
    idex_t idex_d;
    idex_t idex_q;

    assign opcode = if_instruction[31:26];
    assign rs_f   = if_instruction[25:21];
    assign rt_f   = if_instruction[20:16];
    assign rd_f   = if_instruction[15:11];
    assign funct  = if_instruction[5:0];

    regfile u_regfile (
        .clk       (clk),
        .reset     (reset),
        .we_i      (wb_we),
        .waddr_i   (wb_rd),
        .wdata_i   (wb_data),
        .raddr_a_i (rs_f),
        .rdata_a_o (rs_rdata),
        .raddr_b_i (rt_f),
        .rdata_b_o (rt_rdata)
    );

    always_comb begin
        dec             = '0;
        legal           = 1'b0;
        uses_rt         = 1'b0;
        dec.pc4         = if_next_pc;
        dec.rs_data     = rs_rdata;
        dec.rt_data     = rt_rdata;
        dec.imm         = {{(XLEN-16){if_instruction[15]}}, if_instruction[15:0]};
        dec.jump_target = {if_next_pc[31:28], if_instruction[25:0], 2'b00};
        dec.rs          = rs_f;
        dec.rt          = rt_f;
        dec.alu_op      = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                uses_rt       = 1'b1;
                legal         = 1'b1;
                dec.rd        = rd_f;
                dec.reg_write = 1'b1;
                case (funct)
                    FUNCT_ADD: dec.alu_op = ALU_ADD;
                    FUNCT_SUB: dec.alu_op = ALU_SUB;
                    FUNCT_AND: dec.alu_op = ALU_AND;
                    FUNCT_OR:  dec.alu_op = ALU_OR;
                    FUNCT_SLT: dec.alu_op = ALU_SLT;
                    default:   legal      = 1'b0;
                endcase
            end
            OP_ADDI: begin
                legal         = 1'b1;
                dec.rd        = rt_f;
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
            end
            OP_LW: begin
                legal         = 1'b1;
                dec.rd        = rt_f;
                dec.alu_src   = 1'b1;
                dec.mem_read  = 1'b1;
                dec.reg_write = 1'b1;
            end
            OP_SW: begin
                legal         = 1'b1;
                uses_rt       = 1'b1;
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
            end
            OP_BEQ: begin
                legal      = 1'b1;
                uses_rt    = 1'b1;
                dec.branch = 1'b1;
                dec.alu_op = ALU_SUB;
            end
            OP_J: begin
                legal    = 1'b1;
                dec.jump = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    // Load-use hazard against the load currently sitting in ID/EX; the
    // bubble injected below clears ex_mem_read, so the stall self-terminates.
    assign stall = idex_q.mem_read && (idex_q.rt != '0) &&
                   ((idex_q.rt == rs_f) || ((idex_q.rt == rt_f) && uses_rt));

    always_comb begin
        idex_d = dec;
        if (flush || stall || !legal) begin
            idex_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign ex_pc4         = idex_q.pc4;
    assign ex_rs_data     = idex_q.rs_data;
    assign ex_rt_data     = idex_q.rt_data;
    assign ex_imm         = idex_q.imm;
    assign ex_rs          = idex_q.rs;
    assign ex_rt          = idex_q.rt;
    assign ex_rd          = idex_q.rd;
    assign ex_alu_op      = idex_q.alu_op;
    assign ex_alu_src     = idex_q.alu_src;
    assign ex_reg_write   = idex_q.reg_write;
    assign ex_mem_read    = idex_q.mem_read;
    assign ex_mem_write   = idex_q.mem_write;
    assign ex_branch      = idex_q.branch;
    assign ex_jump        = idex_q.jump;
    assign ex_jump_target = idex_q.jump_target;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: decode, register-file bypass, load-use stall,
// flush priority and asynchronous reset.
module tb_id_stage;

    logic        clk;
    logic        reset;
    logic [31:0] if_instruction;
    logic [31:0] if_next_pc;
    logic        flush;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        stall;
    logic [31:0] ex_pc4;
    logic [31:0] ex_rs_data;
    logic [31:0] ex_rt_data;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic [4:0]  ex_rd;
    logic [2:0]  ex_alu_op;
    logic        ex_alu_src;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_branch;
    logic        ex_jump;
    logic [31:0] ex_jump_target;

    int total = 0;
    int bad   = 0;

    id_stage dut (
        .clk            (clk),
        .reset          (reset),
        .if_instruction (if_instruction),
        .if_next_pc     (if_next_pc),
        .flush          (flush),
        .wb_we          (wb_we),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .stall          (stall),
        .ex_pc4         (ex_pc4),
        .ex_rs_data     (ex_rs_data),
        .ex_rt_data     (ex_rt_data),
        .ex_imm         (ex_imm),
        .ex_rs          (ex_rs),
        .ex_rt          (ex_rt),
        .ex_rd          (ex_rd),
        .ex_alu_op      (ex_alu_op),
        .ex_alu_src     (ex_alu_src),
        .ex_reg_write   (ex_reg_write),
        .ex_mem_read    (ex_mem_read),
        .ex_mem_write   (ex_mem_write),
        .ex_branch      (ex_branch),
        .ex_jump        (ex_jump),
        .ex_jump_target (ex_jump_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit
    // after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] ADD_3_1_2  = 32'h0022_1820;
    localparam logic [31:0] ADD_3_0_2  = 32'h0002_1820;
    localparam logic [31:0] ADD_5_4_2  = 32'h0082_2820;
    localparam logic [31:0] ADD_5_2_4  = 32'h0044_2820;
    localparam logic [31:0] ADD_3_5_0  = 32'h00A0_1820;
    localparam logic [31:0] LW_4_M4_1  = 32'h8C24_FFFC;
    localparam logic [31:0] LW_4_0_1   = 32'h8C24_0000;
    localparam logic [31:0] ADDI_4_1_5 = 32'h2024_0005;
    localparam logic [31:0] J_100      = 32'h0800_0100;
    localparam logic [31:0] ILLEGAL    = 32'hFC00_0000;

    initial begin
        reset          = 1'b1;
        if_instruction = '0;
        if_next_pc     = '0;
        flush          = 1'b0;
        wb_we          = 1'b0;
        wb_rd          = '0;
        wb_data        = '0;

        // Reset state
        #3;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_regw", {31'd0, ex_reg_write}, 32'd0);
        chk("rst_pc4", ex_pc4, 32'd0);
        step();
        reset = 1'b0;

        // Preload r1 = 7, r2 = 3
        wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'd7;
        step();
        wb_rd = 5'd2; wb_data = 32'd3;
        step();
        wb_we = 1'b0;

        // add r3, r1, r2
        if_instruction = ADD_3_1_2; if_next_pc = 32'h0000_1004;
        step();
        chk("add_rs_data", ex_rs_data, 32'd7);
        chk("add_rt_data", ex_rt_data, 32'd3);
        chk("add_rd", {27'd0, ex_rd}, 32'd3);
        chk("add_alu_op", {29'd0, ex_alu_op}, 32'd0);
        chk("add_regw", {31'd0, ex_reg_write}, 32'd1);
        chk("add_alu_src", {31'd0, ex_alu_src}, 32'd0);
        chk("add_pc4", ex_pc4, 32'h0000_1004);

        // lw r4, -4(r1)
        if_instruction = LW_4_M4_1; if_next_pc = 32'h0000_1008;
        step();
        chk("lw_imm", ex_imm, 32'hFFFF_FFFC);
        chk("lw_rd", {27'd0, ex_rd}, 32'd4);
        chk("lw_memrd", {31'd0, ex_mem_read}, 32'd1);
        chk("lw_alu_src", {31'd0, ex_alu_src}, 32'd1);

        // j 0x100 right behind the load: no register overlap, no stall
        if_instruction = J_100; if_next_pc = 32'h4000_0010;
        #1;
        chk("j_nostall", {31'd0, stall}, 32'd0);
        step();
        chk("j_target", ex_jump_target, 32'h4000_0400);
        chk("j_jump", {31'd0, ex_jump}, 32'd1);
        chk("j_regw", {31'd0, ex_reg_write}, 32'd0);

        // Writeback bypass into rs in the same cycle
        if_instruction = ADD_3_1_2; if_next_pc = 32'h0000_2004;
        wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'h0000_DEAD;
        step();
        chk("byp_rs_data", ex_rs_data, 32'h0000_DEAD);
        chk("byp_rt_data", ex_rt_data, 32'd3);

        // Writes to r0 are ignored, both bypassed and stored
        if_instruction = ADD_3_0_2; wb_rd = 5'd0; wb_data = 32'h0000_1234;
        step();
        chk("r0_byp", ex_rs_data, 32'd0);
        wb_we = 1'b0;
        step();
        chk("r0_stored", ex_rs_data, 32'd0);

        // Load-use: lw r4 then add r5, r4, r2
        if_instruction = LW_4_0_1;
        step();
        if_instruction = ADD_5_4_2;
        #1;
        chk("lu_stall", {31'd0, stall}, 32'd1);
        step();
        chk("lu_bub_regw", {31'd0, ex_reg_write}, 32'd0);
        chk("lu_bub_memrd", {31'd0, ex_mem_read}, 32'd0);
        chk("lu_bub_rd", {27'd0, ex_rd}, 32'd0);
        chk("lu_stall_clr", {31'd0, stall}, 32'd0);
        step();
        chk("lu_add_rs", {27'd0, ex_rs}, 32'd4);
        chk("lu_add_rd", {27'd0, ex_rd}, 32'd5);
        chk("lu_add_regw", {31'd0, ex_reg_write}, 32'd1);

        // Add reading r4 behind a non-load: no stall
        if_instruction = ADD_5_2_4;
        #1;
        chk("add_rt4_nostall", {31'd0, stall}, 32'd0);
        step();

        // addi writing r4 behind lw r4: rt is a destination, no stall
        if_instruction = LW_4_0_1;
        step();
        if_instruction = ADDI_4_1_5;
        #1;
        chk("addi_nostall", {31'd0, stall}, 32'd0);
        step();
        chk("addi_alu_src", {31'd0, ex_alu_src}, 32'd1);
        chk("addi_rd", {27'd0, ex_rd}, 32'd4);
        chk("addi_imm", ex_imm, 32'd5);
        chk("addi_memrd", {31'd0, ex_mem_read}, 32'd0);

        // add reading r4 through rt behind lw r4 stalls; flush also asserted
        if_instruction = LW_4_0_1;
        step();
        if_instruction = ADD_5_2_4;
        #1;
        chk("rt_stall", {31'd0, stall}, 32'd1);
        flush = 1'b1;
        step();
        chk("fl_stall_regw", {31'd0, ex_reg_write}, 32'd0);
        chk("fl_stall_rs", {27'd0, ex_rs}, 32'd0);
        chk("fl_stall_memrd", {31'd0, ex_mem_read}, 32'd0);

        // Flush alone squashes a legal instruction
        if_instruction = ADD_3_1_2;
        step();
        chk("fl_regw", {31'd0, ex_reg_write}, 32'd0);
        chk("fl_rd", {27'd0, ex_rd}, 32'd0);
        flush = 1'b0;

        // Illegal opcode behind a load: bubble, no stall
        if_instruction = LW_4_0_1;
        step();
        if_instruction = ILLEGAL;
        #1;
        chk("ill_nostall", {31'd0, stall}, 32'd0);
        step();
        chk("ill_regw", {31'd0, ex_reg_write}, 32'd0);
        chk("ill_memrd", {31'd0, ex_mem_read}, 32'd0);
        chk("ill_pc4", ex_pc4, 32'd0);

        // Asynchronous reset mid-run clears ID/EX and the register file
        if_instruction = ADD_3_1_2; if_next_pc = 32'h0000_3004;
        wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'h0000_0055;
        step();
        wb_we = 1'b0;
        chk("pre_rst_regw", {31'd0, ex_reg_write}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("mrst_regw", {31'd0, ex_reg_write}, 32'd0);
        chk("mrst_pc4", ex_pc4, 32'd0);
        chk("mrst_rs_data", ex_rs_data, 32'd0);
        chk("mrst_stall", {31'd0, stall}, 32'd0);
        reset = 1'b0;
        if_instruction = ADD_3_5_0;
        step();
        chk("r5_cleared", ex_rs_data, 32'd0);
        chk("post_rst_rs", {27'd0, ex_rs}, 32'd5);
        chk("post_rst_regw", {31'd0, ex_reg_write}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
